// File: rtl/next_pc_predictor_if.sv
// next_pc_predictor_if: fetch-side and EX-resolve signals of the next-PC predictor.
interface next_pc_predictor_if;
  logic        stall_i;
  logic [31:0] pc_i;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_taken_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic [31:0] pc_next_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        flush_o;
  logic [31:0] branch_cnt_o;
  logic [31:0] mispred_cnt_o;
  modport slave (
    input  stall_i, pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    output pc_next_o, pred_taken_o, pred_target_o, flush_o, branch_cnt_o, mispred_cnt_o
  );
  modport master (
    output stall_i, pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    input  pc_next_o, pred_taken_o, pred_target_o, flush_o, branch_cnt_o, mispred_cnt_o
  );
endinterface

// File: rtl/next_pc_predictor.sv
// next_pc_predictor: direct-mapped BTB with 2-bit counters, EX redirect/flush and perf counters.
module next_pc_predictor #(
  parameter int ENTRIES = 16,
  parameter int INDEX_W = 4
) (
  input logic clk_i,
  input logic rst_i,
  next_pc_predictor_if.slave bus
);
  localparam int TAG_W = 32 - INDEX_W - 2;
  logic               valid [ENTRIES];
  logic [TAG_W-1:0]   tag   [ENTRIES];
  logic [31:0]        target[ENTRIES];
  logic [1:0]         ctr   [ENTRIES];
  logic [INDEX_W-1:0] l_idx, u_idx;
  logic               hit, u_hit, mispred, upd;
  logic [31:0]        seq_pc;
  logic [1:0]         u_ctr;
  always_comb begin
    l_idx  = bus.pc_i[INDEX_W+1:2];
    u_idx  = bus.ex_pc_i[INDEX_W+1:2];
    seq_pc = bus.pc_i + 32'd4;
    hit    = valid[l_idx] && tag[l_idx] == bus.pc_i[31:INDEX_W+2];
    u_hit  = valid[u_idx] && tag[u_idx] == bus.ex_pc_i[31:INDEX_W+2];
    u_ctr  = bus.ex_taken_i ? (ctr[u_idx] == 2'b11 ? 2'b11 : ctr[u_idx] + 2'd1)
                            : (ctr[u_idx] == 2'b00 ? 2'b00 : ctr[u_idx] - 2'd1);
    mispred = bus.ex_valid_i && (bus.ex_taken_i != bus.ex_pred_taken_i ||
              (bus.ex_taken_i && bus.ex_target_i != bus.ex_pred_target_i));
    upd    = bus.ex_valid_i && !bus.stall_i;
    bus.pred_taken_o  = hit && ctr[l_idx][1];
    bus.pred_target_o = hit ? target[l_idx] : seq_pc;
    bus.flush_o       = mispred;
    bus.pc_next_o     = mispred ? (bus.ex_taken_i ? bus.ex_target_i : bus.ex_pc_i + 32'd4)
                                : (bus.pred_taken_o ? bus.pred_target_o : seq_pc);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= 2'b01;
      end
    end else if (upd) begin
      if (u_hit) begin
        ctr[u_idx] <= u_ctr;
        if (bus.ex_taken_i) target[u_idx] <= bus.ex_target_i;
      end else if (bus.ex_taken_i) begin
        valid[u_idx]  <= 1'b1;
        tag[u_idx]    <= bus.ex_pc_i[31:INDEX_W+2];
        target[u_idx] <= bus.ex_target_i;
        ctr[u_idx]    <= 2'b10;
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.branch_cnt_o  <= '0;
      bus.mispred_cnt_o <= '0;
    end else if (upd) begin
      bus.branch_cnt_o  <= bus.branch_cnt_o + {31'd0, bus.branch_cnt_o != '1};
      bus.mispred_cnt_o <= bus.mispred_cnt_o + {31'd0, mispred && bus.mispred_cnt_o != '1};
    end
  end
endmodule

// File: tb/tb_next_pc_predictor.sv
// tb_next_pc_predictor: directed vectors with hand-computed expectations for next_pc_predictor.
module tb_next_pc_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  next_pc_predictor_if bus ();
  next_pc_predictor #(.ENTRIES(16), .INDEX_W(4)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid_i = 1'b1;
    bus.ex_pc_i = pc;
    bus.ex_taken_i = tk;
    bus.ex_target_i = tgt;
    bus.ex_pred_taken_i = ptk;
    bus.ex_pred_target_i = ptgt;
  endtask
  task automatic idle();
    bus.ex_valid_i = 1'b0;
    bus.ex_taken_i = 1'b0;
    bus.ex_pred_taken_i = 1'b0;
  endtask
  initial begin
    bus.stall_i = 1'b0;
    bus.pc_i = 32'h100;
    bus.ex_pc_i = '0;
    bus.ex_target_i = '0;
    bus.ex_pred_target_i = '0;
    idle();
    step();
    step();
    check("rst_pc_next", bus.pc_next_o, 32'h104);
    check("rst_pred_taken", {31'd0, bus.pred_taken_o}, 32'd0);
    check("rst_flush", {31'd0, bus.flush_o}, 32'd0);
    check("rst_branch_cnt", bus.branch_cnt_o, 32'd0);
    check("rst_mispred_cnt", bus.mispred_cnt_o, 32'd0);
    rst = 1'b0;
    step();
    // cold taken branch: same-cycle redirect, lookup still sees pre-update table
    bus.pc_i = 32'h40;
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    check("cold_flush", {31'd0, bus.flush_o}, 32'd1);
    check("cold_pc_next", bus.pc_next_o, 32'h80);
    check("cold_pre_update_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    step();
    idle();
    #1;
    check("cold_pred_taken", {31'd0, bus.pred_taken_o}, 32'd1);
    check("cold_pred_target", bus.pred_target_o, 32'h80);
    check("cold_next", bus.pc_next_o, 32'h80);
    check("cold_flush_off", {31'd0, bus.flush_o}, 32'd0);
    check("cold_branch_cnt", bus.branch_cnt_o, 32'd1);
    check("cold_mispred_cnt", bus.mispred_cnt_o, 32'd1);
    // hysteresis: 10 -> 11 -> 11 -> 10 -> 01
    for (int i = 0; i < 2; i++) begin
      resolve(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
      #1;
      check("hyst_taken_noflush", {31'd0, bus.flush_o}, 32'd0);
      step();
    end
    resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    check("hyst_nt1_flush", {31'd0, bus.flush_o}, 32'd1);
    check("hyst_nt1_pc_next", bus.pc_next_o, 32'h44);
    step();
    idle();
    #1;
    check("hyst_nt1_still_taken", {31'd0, bus.pred_taken_o}, 32'd1);
    check("hyst_nt1_branch_cnt", bus.branch_cnt_o, 32'd4);
    check("hyst_nt1_mispred_cnt", bus.mispred_cnt_o, 32'd2);
    resolve(32'h40, 1'b0, 32'h0, 1'b1, 32'h80);
    step();
    idle();
    #1;
    check("hyst_nt2_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    check("hyst_nt2_target_kept", bus.pred_target_o, 32'h80);
    check("hyst_nt2_pc_next", bus.pc_next_o, 32'h44);
    check("hyst_nt2_mispred_cnt", bus.mispred_cnt_o, 32'd3);
    // target mispredict: retrain to taken (01 -> 10), then resolve to a new target
    resolve(32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    idle();
    #1;
    check("tgt_retrained", {31'd0, bus.pred_taken_o}, 32'd1);
    resolve(32'h40, 1'b1, 32'hC0, 1'b1, 32'h80);
    #1;
    check("tgt_flush", {31'd0, bus.flush_o}, 32'd1);
    check("tgt_pc_next", bus.pc_next_o, 32'hC0);
    step();
    idle();
    #1;
    check("tgt_new_target", bus.pred_target_o, 32'hC0);
    check("tgt_branch_cnt", bus.branch_cnt_o, 32'd7);
    check("tgt_mispred_cnt", bus.mispred_cnt_o, 32'd5);
    // alias: 0x80 shares index 0 with 0x40 but has a different tag
    bus.pc_i = 32'h80;
    #1;
    check("alias_pred", {31'd0, bus.pred_taken_o}, 32'd0);
    check("alias_pc_next", bus.pc_next_o, 32'h84);
    // stalled mispredict held 3 cycles: flush stays high, nothing updates
    bus.stall_i = 1'b1;
    resolve(32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_flush", {31'd0, bus.flush_o}, 32'd1);
      check("stall_branch_cnt", bus.branch_cnt_o, 32'd7);
      check("stall_no_alloc", {31'd0, bus.pred_taken_o}, 32'd0);
      step();
    end
    bus.stall_i = 1'b0;
    step();
    idle();
    #1;
    check("release_branch_cnt", bus.branch_cnt_o, 32'd8);
    check("release_mispred_cnt", bus.mispred_cnt_o, 32'd6);
    check("release_alloc_pred", {31'd0, bus.pred_taken_o}, 32'd1);
    check("release_alloc_target", bus.pc_next_o, 32'h200);
    bus.pc_i = 32'h40;
    #1;
    check("replaced_old_miss", {31'd0, bus.pred_taken_o}, 32'd0);
    bus.pc_i = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_next", bus.pc_next_o, 32'h0);
    // async reset mid-operation with a resolve pending: clears at once, no update while high
    bus.pc_i = 32'h100;
    resolve(32'h140, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_branch_cnt", bus.branch_cnt_o, 32'd0);
    check("mid_rst_mispred_cnt", bus.mispred_cnt_o, 32'd0);
    step();
    idle();
    #1;
    check("mid_rst_pc_next", bus.pc_next_o, 32'h104);
    check("mid_rst_flush", {31'd0, bus.flush_o}, 32'd0);
    check("mid_rst_no_update", bus.branch_cnt_o, 32'd0);
    bus.pc_i = 32'h140;
    #1;
    check("mid_rst_no_alloc", {31'd0, bus.pred_taken_o}, 32'd0);
    bus.pc_i = 32'h80;
    #1;
    check("mid_rst_cleared", {31'd0, bus.pred_taken_o}, 32'd0);
    check("mid_rst_target", bus.pred_target_o, 32'h84);
    rst = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/next_pc_predictor.md
# next_pc_predictor

Next-PC generation stage that sits directly upstream of the PC register and drives its `pc_i` input. It predicts the next fetch address with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It redirects fetch on mispredictions resolved in EX, raises the flush for the front-end pipeline registers, and keeps branch/mispredict performance counters.

## Interface
- `ENTRIES`, default 16: number of BTB entries; must be a power of 2, minimum 2.
- `INDEX_W`, default 4: log2(ENTRIES); index bits.
- `clk_i` in 1: clock; all state updates on posedge.
- `rst_i` in 1: asynchronous, active-high reset.
- `stall_i` in 1: pipeline freeze (cache/hazard stall); blocks all state updates.
- `pc_i` in 32: current PC (PC register output).
- `ex_valid_i` in 1: a branch/jump is resolved in EX this cycle.
- `ex_pc_i` in 32: PC of the resolved branch.
- `ex_taken_i` in 1: actual direction.
- `ex_target_i` in 32: actual taken target.
- `ex_pred_taken_i` in 1: prediction carried down the pipe with this branch.
- `ex_pred_target_i` in 32: predicted target carried down the pipe.
- `pc_next_o` out 32: next PC, to PC register `pc_i`.
- `pred_taken_o` out 1: prediction for `pc_i`, to be carried down the pipe.
- `pred_target_o` out 32: predicted target for `pc_i`, to be carried down the pipe.
- `flush_o` out 1: mispredict; flushes IF/ID and ID/EX.
- `branch_cnt_o` out 32: resolved-branch count.
- `mispred_cnt_o` out 32: mispredict count.

## Operation
- Index = addr[INDEX_W+1:2]. Tag = addr[31:INDEX_W+2]. Each entry holds valid, tag, 32-bit target, and a 2-bit counter.
- Lookup is combinational on `pc_i`.
  - hit = valid && tag match.
  - `pred_taken_o` = hit && ctr[1].
  - `pred_target_o` = hit ? target : pc_i+4.
- Mispredict = `ex_valid_i` && (`ex_taken_i` != `ex_pred_taken_i` || (`ex_taken_i` && `ex_target_i` != `ex_pred_target_i`)).
- Next-PC priority, all combinational:
  - On mispredict: `pc_next_o` = `ex_taken_i` ? `ex_target_i` : `ex_pc_i`+4, and `flush_o`=1. This overrides the prediction.
  - Otherwise: `pc_next_o` = `pred_taken_o` ? `pred_target_o` : `pc_i`+4.
- `flush_o` is not gated by `stall_i`. It stays high while a stalled mispredicted branch is held in EX.
- Table update occurs on posedge when `ex_valid_i` && !`stall_i`, at the index of `ex_pc_i`:
  - Hit: the counter saturating-increments if taken and decrements if not taken; the target is overwritten with `ex_target_i` if taken.
  - Miss and taken: allocate the entry. valid=1, tag, target=`ex_target_i`, ctr=2'b10. Any existing entry is replaced.
  - Miss and not taken: no change.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T. Counters saturate at 00 and 11.
- Performance counters update under the same condition as the table:
  - `branch_cnt_o` increments by 1 per resolved branch.
  - `mispred_cnt_o` increments by 1 per mispredict.
  - Both saturate at 0xFFFF_FFFF.
- All adds are 32-bit and wrap modulo 2^32 (e.g. pc 0xFFFF_FFFC + 4 = 0x0).

## Timing
- Prediction and redirect have zero-cycle latency (combinational). The PC register captures `pc_next_o` at the next posedge.
- Table and counters update on posedge, so the same-index lookup in the update cycle sees pre-update contents. The new contents are visible one cycle later.
- Simultaneous lookup and update of different indices are independent.
- `rst_i` asserted at any time, including mid-stall or with `ex_valid_i` high:
  - All entries become valid=0 and ctr=01 immediately; both counters become 0.
  - Outputs after reset: `pred_taken_o`=0, `pred_target_o`=`pc_i`+4, `pc_next_o`=`pc_i`+4, and `flush_o`=0 when `ex_valid_i`=0.
  - No update occurs while `rst_i` is high.
- `stall_i` freezes all state. Outputs keep tracking the inputs combinationally.

## Test plan
- Reset: pulse `rst_i` mid-operation with `pc_i`=0x100, `ex_valid_i`=0 -> `pc_next_o`=0x104, `pred_taken_o`=0, `flush_o`=0, both counters 0.
- Cold taken branch: `ex_valid_i`=1, `ex_pc_i`=0x40, taken, target 0x80, pred_taken=0 -> same cycle `flush_o`=1 and `pc_next_o`=0x80. Next cycle, `pc_i`=0x40 -> `pred_taken_o`=1, `pc_next_o`=0x80; `mispred_cnt_o`=1, `branch_cnt_o`=1.
- Hysteresis on 0x40 (ctr=10):
  - Two taken resolves -> ctr=11.
  - One not-taken resolve with pred_taken=1 -> `flush_o`=1, `pc_next_o`=0x44, ctr=10; lookup of 0x40 still predicts taken.
  - A second not-taken resolve -> ctr=01, predicts not taken.
- Target mispredict: 0x40 predicted taken to 0x80, resolves taken to 0xC0 -> `flush_o`=1, `pc_next_o`=0xC0; next lookup of 0x40 -> `pred_target_o`=0xC0.
- Alias and stall (ENTRIES=16):
  - With 0x40 allocated, `pc_i`=0x80 (same index, different tag) -> `pred_taken_o`=0, `pc_next_o`=0x84.
  - Hold a mispredicting resolve with `stall_i`=1 for 3 cycles -> `flush_o` high throughout, no table or counter change.
  - Release the stall -> exactly one update; `branch_cnt_o` increments by 1.
